// File: rtl/fir_xifu_pkg.sv
// Shared types and constants for the FIR X-interface unit.
package fir_xifu_pkg;

  localparam int XIF_ID_W   = 4;
  localparam int XIF_DATA_W = 32;
  localparam int XIF_RD_W   = 5;

  // One X-interface result beat at the default id width.
  typedef struct packed {
    logic [XIF_ID_W-1:0]   id;
    logic [XIF_DATA_W-1:0] data;
    logic [XIF_RD_W-1:0]   rd;
    logic                  we;
  } fir_xifu_result_t;

endpackage

// File: rtl/fir_xifu_result_fifo.sv
// Small power-of-two FIFO for memory-completion results.
// A push at full is accepted only when a pop frees a slot in the same cycle.
module fir_xifu_result_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  T                 wdata,
  output T                 rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wptr, rptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_W'(1);
      if (do_pop)  rptr <= rptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset; only slots below count are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/fir_xifu_result_arb.sv
// Merges the unstallable memory-completion path and the stallable
// arithmetic path into one in-order X-interface result stream.
module fir_xifu_result_arb
  import fir_xifu_pkg::*;
#(
  parameter int ID_W  = XIF_ID_W,
  parameter int DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            mem_valid_i,
  input  logic [ID_W-1:0] mem_id_i,
  input  logic [31:0]     mem_data_i,
  input  logic [4:0]      mem_rd_i,
  input  logic            mem_we_i,
  input  logic            alu_valid_i,
  output logic            alu_ready_o,
  input  logic [ID_W-1:0] alu_id_i,
  input  logic [31:0]     alu_data_i,
  input  logic [4:0]      alu_rd_i,
  input  logic            alu_we_i,
  output logic            result_valid_o,
  input  logic            result_ready_i,
  output logic [ID_W-1:0] result_id_o,
  output logic [31:0]     result_data_o,
  output logic [4:0]      result_rd_o,
  output logic            result_we_o,
  output logic            busy_o,
  output logic            overflow_o
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Same layout as fir_xifu_result_t, but sized by this instance's id width.
  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [31:0]     data;
    logic [4:0]      rd;
    logic            we;
  } res_t;

  res_t             mem_res, alu_res, head, out_q;
  logic             out_free, fifo_push, fifo_pop;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  assign mem_res = '{id: mem_id_i, data: mem_data_i, rd: mem_rd_i, we: mem_we_i};
  assign alu_res = '{id: alu_id_i, data: alu_data_i, rd: alu_rd_i, we: alu_we_i};

  assign out_free = !result_valid_o || result_ready_i;
  // Queued entries always drain first; a new completion may bypass only
  // when nothing older is waiting and the output slot is free.
  assign fifo_pop  = out_free && !fifo_empty;
  assign fifo_push = mem_valid_i && (!out_free || !fifo_empty);
  // Memory completions cannot be stalled, so the ALU only wins an idle slot.
  assign alu_ready_o = out_free && fifo_empty && !mem_valid_i;

  fir_xifu_result_fifo #(
    .DEPTH (DEPTH),
    .T     (res_t)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (mem_res),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Output register with priority FIFO head > bypass completion > ALU.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      result_valid_o <= 1'b0;
      out_q          <= '0;
    end else if (out_free) begin
      if (!fifo_empty) begin
        result_valid_o <= 1'b1;
        out_q          <= head;
      end else if (mem_valid_i) begin
        result_valid_o <= 1'b1;
        out_q          <= mem_res;
      end else if (alu_valid_i) begin
        result_valid_o <= 1'b1;
        out_q          <= alu_res;
      end else begin
        result_valid_o <= 1'b0;
      end
    end
  end

  // Sticky drop flag: a completion arrived with no slot left and none freed.
  always_ff @(posedge clk_i) begin
    if (rst_i)                                      overflow_o <= 1'b0;
    else if (fifo_push && fifo_full && !fifo_pop)   overflow_o <= 1'b1;
  end

  assign result_id_o   = out_q.id;
  assign result_data_o = out_q.data;
  assign result_rd_o   = out_q.rd;
  assign result_we_o   = out_q.we;
  assign busy_o        = (fifo_count != '0) || result_valid_o;

endmodule

// File: tb/tb_fir_xifu_result_arb.sv
// Directed plus randomized checks of the result arbiter against a
// queue-based reference model of the merge rules.
module tb_fir_xifu_result_arb;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
  } ent_t;

  logic        clk = 0;
  logic        rst;
  logic        mem_valid, mem_we, alu_valid, alu_we, rdy;
  logic [3:0]  mem_id, alu_id;
  logic [31:0] mem_data, alu_data;
  logic [4:0]  mem_rd, alu_rd;
  logic        alu_ready, res_valid, res_we, busy, ovf;
  logic [3:0]  res_id;
  logic [31:0] res_data;
  logic [4:0]  res_rd;

  int checks = 0;
  int failures = 0;

  // Reference model state
  bit   m_v, m_ovf, fld_chk, alu_taken;
  ent_t m_e;
  ent_t q[$];

  always #5 clk = ~clk;

  fir_xifu_result_arb #(.ID_W(4), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst),
    .mem_valid_i(mem_valid), .mem_id_i(mem_id), .mem_data_i(mem_data),
    .mem_rd_i(mem_rd), .mem_we_i(mem_we),
    .alu_valid_i(alu_valid), .alu_ready_o(alu_ready), .alu_id_i(alu_id),
    .alu_data_i(alu_data), .alu_rd_i(alu_rd), .alu_we_i(alu_we),
    .result_valid_o(res_valid), .result_ready_i(rdy),
    .result_id_o(res_id), .result_data_o(res_data), .result_rd_o(res_rd),
    .result_we_o(res_we), .busy_o(busy), .overflow_o(ovf)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic set_mem(input bit v, input logic [3:0] id);
    mem_valid = v; mem_id = id;
    mem_data = $urandom; mem_rd = 5'($urandom); mem_we = 1'($urandom);
  endtask

  task automatic new_alu(input bit v, input logic [3:0] id);
    alu_valid = v; alu_id = id;
    alu_data = $urandom; alu_rd = 5'($urandom); alu_we = 1'($urandom);
  endtask

  // One clock: check the combinational ready, clock, advance model, check outputs.
  task automatic cyc();
    bit   free, consumed;
    ent_t me, ae;
    #1;
    free = !m_v || rdy;
    check("alu_ready", alu_ready, free && q.size() == 0 && !mem_valid);
    me = '{id: mem_id, data: mem_data, rd: mem_rd, we: mem_we};
    ae = '{id: alu_id, data: alu_data, rd: alu_rd, we: alu_we};
    alu_taken = 0;
    @(posedge clk);
    if (rst) begin
      m_v = 0; m_e = '0; q.delete(); m_ovf = 0; fld_chk = 1;
    end else begin
      consumed = 0; fld_chk = 0;
      if (free) begin
        if (q.size() > 0)   begin m_e = q.pop_front(); m_v = 1; end
        else if (mem_valid) begin m_e = me; m_v = 1; consumed = 1; end
        else if (alu_valid) begin m_e = ae; m_v = 1; alu_taken = 1; end
        else m_v = 0;
      end
      if (mem_valid && !consumed) begin
        if (q.size() < DEPTH) q.push_back(me);
        else m_ovf = 1;
      end
    end
    #1;
    check("result_valid", res_valid, m_v);
    check("busy", busy, m_v || q.size() > 0);
    check("overflow", ovf, m_ovf);
    if (m_v || fld_chk) check("fields", {res_id, res_data, res_rd, res_we}, m_e);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; cyc(); rst = 0;
  endtask

  initial begin
    rst = 1; rdy = 0;
    set_mem(0, 0); new_alu(0, 0);
    @(negedge clk);

    // Reset state
    cyc(); cyc(); rst = 0;
    check("rst_alu_ready", alu_ready, 1);

    // Single completion with ready high
    rdy = 1;
    set_mem(1, 3); mem_data = 32'h1004; mem_rd = 10; mem_we = 1;
    cyc();
    set_mem(0, 0);
    check("single_valid", res_valid, 1);
    check("single_id", res_id, 3);
    check("single_data", res_data, 32'h1004);
    check("single_rd", res_rd, 10);
    cyc();
    check("single_busy_low", busy, 0);

    // Backpressure ordering
    rdy = 0;
    for (int i = 1; i <= 3; i++) begin set_mem(1, 4'(i)); cyc(); end
    set_mem(0, 0);
    check("bp_head", res_id, 1);
    rdy = 1;
    for (int i = 1; i <= 3; i++) begin
      check("bp_order", res_id, 4'(i));
      cyc();
    end
    check("bp_no_ovf", ovf, 0);

    // Contention: memory wins, ALU holds its fields and goes next
    new_alu(1, 5); set_mem(1, 6);
    #1 check("contend_ready", alu_ready, 0);
    cyc();
    set_mem(0, 0);
    check("contend_mem_first", res_id, 6);
    cyc();
    check("contend_alu_taken", alu_taken, 1);
    new_alu(0, 0);
    check("contend_alu_next", res_id, 5);
    cyc();

    // Overflow at DEPTH+1 absorbed completions
    do_reset();
    rdy = 0;
    for (int i = 0; i <= 5; i++) begin
      set_mem(1, 4'(i)); cyc();
      check("ovf_flag", ovf, (i == 5));
    end
    set_mem(0, 0); rdy = 1;
    for (int i = 0; i <= 4; i++) begin
      check("ovf_drain", res_id, 4'(i));
      cyc();
    end
    check("ovf_sticky", ovf, 1);
    check("ovf_empty", res_valid, 0);

    // Push into a full FIFO while it pops
    do_reset();
    rdy = 0;
    for (int i = 0; i <= 4; i++) begin set_mem(1, 4'(i)); cyc(); end
    rdy = 1; set_mem(1, 9); cyc(); set_mem(0, 0);
    check("full_pp_ovf", ovf, 0);
    for (int i = 1; i <= 5; i++) begin
      check("full_pp_order", res_id, (i == 5) ? 4'd9 : 4'(i));
      cyc();
    end

    // Reset mid-operation with buffered entries and overflow set
    rdy = 0;
    for (int i = 1; i <= 6; i++) begin set_mem(1, 4'(i)); cyc(); end
    set_mem(0, 0);
    check("mid_busy", busy, 1);
    do_reset();
    check("mid_valid", res_valid, 0);
    check("mid_busy_low", busy, 0);
    check("mid_ovf", ovf, 0);
    rdy = 1; set_mem(1, 7); cyc(); set_mem(0, 0);
    check("mid_bypass_valid", res_valid, 1);
    check("mid_bypass_id", res_id, 7);
    cyc();

    // Randomized traffic with stall bursts and occasional resets
    for (int n = 0; n < 800; n++) begin
      rst = (n % 150 == 149);
      rdy = ((n % 50) < 7) ? 1'b0 : ($urandom_range(0, 3) != 0);
      set_mem($urandom_range(0, 2) == 0, 4'($urandom));
      if (!alu_valid) new_alu($urandom_range(0, 1) == 1, 4'($urandom));
      cyc();
      if (alu_taken || rst) new_alu(0, 0);
    end
    rst = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case a wait never returns
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
